// File: rtl/att_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : att_serial_rx_if
// Brief    : Three-wire attenuator serial lines plus receiver status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface att_serial_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  SI;
    logic                  CLK;
    logic                  LE;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_VALID;
    logic                  FRAME_ERR;
    logic                  BUSY;
    logic                  SETTLED;
    logic [15:0]           FRAME_CNT;

    // master drives the serial lines; slave is the receiver
    modport master (
        output SI, CLK, LE,
        input  DATA_OUT, DATA_VALID, FRAME_ERR, BUSY, SETTLED, FRAME_CNT
    );

    modport slave (
        input  SI, CLK, LE,
        output DATA_OUT, DATA_VALID, FRAME_ERR, BUSY, SETTLED, FRAME_CNT
    );
endinterface
`default_nettype wire

// File: rtl/att_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : att_serial_rx
// Brief    : Oversampling SI/CLK/LE receiver with framing, timeout and settle.
// Revision : 1.0 - initial release
// ============================================================================
module att_serial_rx #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETTLE_CYCLES  = 390
) (
    input  logic           CLK_T,
    input  logic           reset_t,
    att_serial_rx_if.slave bus
);
    localparam int c_BIT_W = $clog2(DATA_WIDTH + 2);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_BIT_W-1:0] c_BIT_FULL = c_BIT_W'(DATA_WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_SAT  = c_BIT_W'(DATA_WIDTH + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                 state_q,      state_d;
    logic [SYNC_STAGES-1:0] si_sync_q,    si_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q,   clk_sync_d;
    logic [SYNC_STAGES-1:0] le_sync_q,    le_sync_d;
    logic                   clk_dly_q,    clk_dly_d;
    logic                   le_dly_q,     le_dly_d;
    logic [DATA_WIDTH-1:0]  shreg_q,      shreg_d;
    logic [c_BIT_W-1:0]     bitcnt_q,     bitcnt_d;
    logic [c_TO_W-1:0]      tocnt_q,      tocnt_d;
    logic [c_SET_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [DATA_WIDTH-1:0]  data_out_q,   data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   busy_q,       busy_d;
    logic                   settled_q,    settled_d;
    logic [15:0]            frame_cnt_q,  frame_cnt_d;

    logic clk_rise;
    logic le_rise;
    logic si_bit;

    // SI is taken from the same stage as CLK so data and clock stay aligned
    assign si_bit   = si_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
    assign le_rise  = le_sync_q[SYNC_STAGES-1]  & ~le_dly_q;

    always_comb begin
        state_d      = state_q;
        si_sync_d    = {si_sync_q[SYNC_STAGES-2:0],  bus.SI};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], bus.CLK};
        le_sync_d    = {le_sync_q[SYNC_STAGES-2:0],  bus.LE};
        clk_dly_d    = clk_sync_q[SYNC_STAGES-1];
        le_dly_d     = le_sync_q[SYNC_STAGES-1];
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        tocnt_d      = tocnt_q;
        settle_cnt_d = settle_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        settled_d    = settled_q;
        frame_cnt_d  = frame_cnt_q;

        if (!settled_q) begin
            if (settle_cnt_q == c_SET_LAST) begin
                settled_d = 1'b1;
            end else begin
                settle_cnt_d = settle_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (le_rise) begin
                    frame_err_d = 1'b1;
                end else if (clk_rise) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = {si_bit, shreg_q[DATA_WIDTH-1:1]};
                    bitcnt_d = c_BIT_W'(1);
                    tocnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                // LE wins over a coincident CLK edge; that CLK edge is dropped
                if (le_rise) begin
                    state_d = ST_LATCH;
                end else if (clk_rise) begin
                    shreg_d  = {si_bit, shreg_q[DATA_WIDTH-1:1]};
                    bitcnt_d = (bitcnt_q == c_BIT_SAT) ? bitcnt_q : bitcnt_q + 1'b1;
                    tocnt_d  = '0;
                end else if (tocnt_q == c_TO_LAST) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    bitcnt_d    = '0;
                    tocnt_d     = '0;
                end else begin
                    tocnt_d = tocnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (bitcnt_q == c_BIT_FULL) begin
                    data_out_d   = shreg_q;
                    data_valid_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    settled_d    = 1'b0;
                    settle_cnt_d = '0;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d  = ST_IDLE;
                bitcnt_d = '0;
                tocnt_d  = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = '0;
                tocnt_d  = '0;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge CLK_T) begin
        if (reset_t) begin
            state_q      <= ST_IDLE;
            si_sync_q    <= '0;
            clk_sync_q   <= '0;
            le_sync_q    <= '0;
            clk_dly_q    <= 1'b0;
            le_dly_q     <= 1'b0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            tocnt_q      <= '0;
            settle_cnt_q <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            settled_q    <= 1'b1;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            si_sync_q    <= si_sync_d;
            clk_sync_q   <= clk_sync_d;
            le_sync_q    <= le_sync_d;
            clk_dly_q    <= clk_dly_d;
            le_dly_q     <= le_dly_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            tocnt_q      <= tocnt_d;
            settle_cnt_q <= settle_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            settled_q    <= settled_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.DATA_OUT   = data_out_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.BUSY       = busy_q;
    assign bus.SETTLED    = settled_q;
    assign bus.FRAME_CNT  = frame_cnt_q;

endmodule
`default_nettype wire
